// File: rtl/freq_div_pkg.sv
// Shared state encoding and parameter defaults for the run-time clock divider.
package freq_div_pkg;

    localparam int CNT_W_DEFAULT    = 8;
    localparam int DEF_HALF_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/div_counter.sv
// Half-period counter and registered divided clock. The tick outputs flag the
// cycle whose closing edge toggles clockout, so the controller can act on it.
module div_counter
    import freq_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    output logic             clockout,
    output logic             fall_tick,
    output logic             rise_tick
);

    logic [CNT_W-1:0] cnt_reg;
    logic             at_end;

    assign at_end    = (cnt_reg == half - CNT_W'(1));
    assign fall_tick = run & at_end & clockout;
    assign rise_tick = run & at_end & ~clockout;

    // clr wins over run so a stop in the low phase never lets a rising edge through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            clockout <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            clockout <= 1'b0;
        end else if (run) begin
            if (at_end) begin
                cnt_reg  <= '0;
                clockout <= ~clockout;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divider controller: owns the ratio register, the config handshake and the
// run/stop FSM; ratio changes and stops are deferred to the falling edge of clockout.
module div_ratio_ctrl
    import freq_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clockout,
    output logic             busy,
    output logic             switch_done,
    output logic             err
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] half_reg, half_next;
    logic [CNT_W-1:0] pend_half_reg, pend_half_next;
    logic             pend_vld_reg, pend_vld_next;
    logic             stop_req_reg, stop_req_next;
    logic             switch_done_next, err_next;
    logic             ctr_run, ctr_clr;
    logic             fall_tick, rise_tick_unused;
    logic             hs, hs_ok;

    assign cfg_ready = ~pend_vld_reg;
    assign hs        = cfg_valid & cfg_ready;
    assign hs_ok     = hs & (cfg_half != '0);
    assign busy      = (state_reg == DRAIN);

    div_counter #(.CNT_W(CNT_W)) u_counter (
        .clk       (clk),
        .rst       (rst),
        .run       (ctr_run),
        .clr       (ctr_clr),
        .half      (half_reg),
        .clockout  (clockout),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick_unused)
    );

    always_comb begin
        state_next       = state_reg;
        half_next        = half_reg;
        pend_half_next   = pend_half_reg;
        pend_vld_next    = pend_vld_reg;
        stop_req_next    = stop_req_reg;
        switch_done_next = 1'b0;
        err_next         = hs & (cfg_half == '0);
        ctr_run          = 1'b0;
        ctr_clr          = 1'b0;

        case (state_reg)
            IDLE: begin
                ctr_clr = 1'b1;
                if (hs_ok) begin
                    half_next        = cfg_half;
                    switch_done_next = 1'b1;
                end
                if (en) state_next = RUN;
            end
            RUN: begin
                ctr_run = 1'b1;
                if (hs_ok) begin
                    pend_vld_next  = 1'b1;
                    pend_half_next = cfg_half;
                    stop_req_next  = ~en;
                    state_next     = DRAIN;
                end else if (!en) begin
                    if (!clockout) begin
                        ctr_clr    = 1'b1;
                        state_next = IDLE;
                    end else if (fall_tick) begin
                        // high phase ends on this edge anyway
                        state_next = IDLE;
                    end else begin
                        stop_req_next = 1'b1;
                        state_next    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ctr_run       = 1'b1;
                stop_req_next = ~en;
                if (fall_tick) begin
                    if (pend_vld_reg) begin
                        half_next        = pend_half_reg;
                        switch_done_next = 1'b1;
                    end else if (hs_ok) begin
                        half_next        = cfg_half;
                        switch_done_next = 1'b1;
                    end
                    pend_vld_next = 1'b0;
                    stop_req_next = 1'b0;
                    state_next    = stop_req_reg ? IDLE : RUN;
                end else if (hs_ok) begin
                    pend_vld_next  = 1'b1;
                    pend_half_next = cfg_half;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            half_reg      <= CNT_W'(DEF_HALF);
            pend_half_reg <= '0;
            pend_vld_reg  <= 1'b0;
            stop_req_reg  <= 1'b0;
            switch_done   <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_reg      <= half_next;
            pend_half_reg <= pend_half_next;
            pend_vld_reg  <= pend_vld_next;
            stop_req_reg  <= stop_req_next;
            switch_done   <= switch_done_next;
            err           <= err_next;
        end
    end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Cycle-table bench for div_ratio_ctrl: expected outputs derived from the
// half-period timing rules, queued per cycle and compared after each edge.
module tb_div_ratio_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready, clockout, busy, switch_done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int step     = 0;

    always #5 clk = ~clk;

    div_ratio_ctrl #(.CNT_W(CNT_W), .DEF_HALF(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clockout    (clockout),
        .busy        (busy),
        .switch_done (switch_done),
        .err         (err)
    );

    // -1 in an expected field means "not checked this cycle"
    typedef struct {
        logic en;
        logic cv;
        int   ch;
        int   co;
        int   sd;
        int   er;
        int   bz;
        int   rdy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic void add(logic e, logic cv, int ch, int co, int sd, int er, int bz, int rdy);
        vec_t v;
        v.en = e; v.cv = cv; v.ch = ch; v.co = co; v.sd = sd; v.er = er; v.bz = bz; v.rdy = rdy;
        tbl.push_back(v);
    endfunction

    // high when the step lies in the second half of a period that began low at step 'fall'
    function automatic int hi(int n, int fall, int half);
        return (((n - fall) % (2 * half)) >= half) ? 1 : 0;
    endfunction

    function automatic void add_range(int a, int b, logic e, int fall, int half, int bz, int rdy);
        for (int n = a; n <= b; n++) add(e, 1'b0, 0, hi(n, fall, half), 0, 0, bz, rdy);
    endfunction

    task automatic check(string name, int act, int exp);
        if (exp >= 0) begin
            n_checks++;
            if (act != exp) begin
                n_fail++;
                $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
            end
        end
    endtask

    task automatic run_table();
        vec_t v;
        vec_t e;
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            en        = v.en;
            cfg_valid = v.cv;
            cfg_half  = CNT_W'(v.ch);
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            step++;
            e = exp_q.pop_front();
            $display("step %0d en=%0b cfg=%0b/%0d clockout=%0b switch_done=%0b err=%0b busy=%0b ready=%0b",
                     step, e.en, e.cv, e.ch, clockout, switch_done, err, busy, cfg_ready);
            check("clockout", int'(clockout), e.co);
            check("switch_done", int'(switch_done), e.sd);
            check("err", int'(err), e.er);
            check("busy", int'(busy), e.bz);
            check("cfg_ready", int'(cfg_ready), e.rdy);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_clockout", int'(clockout), 0);
        check("reset_cfg_ready", int'(cfg_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_switch_done", int'(switch_done), 0);
        check("reset_err", int'(err), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // default divide-by-8, then a mid-high-phase switch to half=2
        add_range(1, 21, 1'b1, 1, 4, 0, 1);
        add(1'b1, 1'b1, 2, 1, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 1, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 1, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 0, 1, 0, 0, -1);
        add_range(26, 33, 1'b1, 25, 2, 0, 1);
        // zero half-period: error pulse only
        add(1'b1, 1'b1, 0, hi(34, 25, 2), 0, 1, 0, 1);
        add_range(35, 41, 1'b1, 25, 2, 0, 1);
        // switch to half=3 starting in the low phase
        add(1'b1, 1'b1, 3, 0, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 1, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 1, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 0, 1, 0, 0, -1);
        add_range(46, 48, 1'b1, 45, 3, 0, 1);
        // stop during high phase: full high phase, then idle
        add(1'b0, 1'b0, 0, 1, 0, 0, 1, 1);
        add(1'b0, 1'b0, 0, 1, 0, 0, 1, 1);
        add(1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        add(1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        // config while idle applies one cycle later
        add(1'b0, 1'b1, 3, 0, 1, 0, 0, 1);
        // stop during low phase: idle on the next cycle
        add(1'b1, 1'b0, 0, 0, 0, 0, 0, 1);
        add(1'b1, 1'b0, 0, 0, 0, 0, 0, 1);
        add(1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        add_range(57, 60, 1'b1, 57, 3, 0, 1);
        // config and stop together
        add(1'b0, 1'b1, 5, 1, 0, 0, 1, 0);
        add(1'b0, 1'b0, 0, 1, 0, 0, 1, 0);
        add(1'b0, 1'b0, 0, 0, 1, 0, 0, -1);
        add(1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        add_range(65, 85, 1'b1, 65, 5, 0, 1);
        // half=1 applied after a long drain
        add(1'b1, 1'b1, 1, 0, 0, 0, 1, 0);
        add_range(87, 94, 1'b1, 65, 5, 1, 0);
        add(1'b1, 1'b0, 0, 0, 1, 0, 0, -1);
        add_range(96, 102, 1'b1, 95, 1, 0, 1);
        // enter drain with half=7 pending
        add(1'b1, 1'b1, 7, 0, 0, 0, 1, 0);
        add(1'b1, 1'b0, 0, 1, 0, 0, 1, 0);
        run_table();

        // asynchronous reset mid-drain
        rst = 1'b0;
        #1;
        check("async_rst_clockout", int'(clockout), 0);
        check("async_rst_cfg_ready", int'(cfg_ready), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_switch_done", int'(switch_done), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step = 0;
        // pending half=7 must be gone: default divide-by-8 again
        add_range(1, 14, 1'b1, 1, 4, 0, 1);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
